e203_ifu_itcm_rdport: RTL and testbench
=======================================

# e203_ifu_itcm_rdport

Read-only ICB slave port that turns instruction-fetch ICB commands from the IFU fetch-to-ICB bridge into accesses on the 64-bit ITCM SRAM, returning a fixed-latency response. It sits directly downstream of the IFU's ITCM ICB master. It also produces the `ifu2itcm_holdup` indication the bridge uses to reuse SRAM output data without re-reading. The SRAM is shared with a higher-priority external master (LSU/debug) arbitrated outside this block.

## Interface
- `AW`, 16: ITCM byte-address width; ITCM size = 2^AW bytes.
- `ITCM_BASE`, 32'h8000_0000: region base; bits [31:AW] compared.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `ifu2itcm_icb_cmd_valid` / `_ready`  in / out  1  command handshake.
- `ifu2itcm_icb_cmd_addr`  in  32  byte address; bits [2:0] ignored.
- `ifu2itcm_icb_rsp_valid` / `_ready`  out / in  1  response handshake.
- `ifu2itcm_icb_rsp_err`  out  1  out-of-region access.
- `ifu2itcm_icb_rsp_rdata`  out  64  fetched doubleword.
- `ifu2itcm_holdup`  out  1  SRAM output still holds the last IFU read.
- `ext_sram_req`  in  1  external master owns SRAM this cycle.
- `itcm_ram_cs`  out  1  SRAM chip select (read only).
- `itcm_ram_addr`  out  AW-3  doubleword index = `cmd_addr[AW-1:3]`.
- `itcm_ram_dout`  in  64  SRAM read data, valid the cycle after `cs`.

## Operation
- Command fire = `cmd_valid & cmd_ready`. `cmd_ready` is forced low while `ext_sram_req` is high.
- In-region fire: `itcm_ram_cs=1` in the same cycle (combinational). The response carries `itcm_ram_dout` one cycle later.
- Out-of-region fire (`addr[31:AW] != ITCM_BASE[31:AW]`): no `cs`. Response one cycle later with `err=1` and `rdata=0`.
- Response states: IDLE -> RD after a fire. In RD, `rsp_valid=1` and rdata comes directly from `itcm_ram_dout`.
  - RD with `rsp_ready=0`: capture dout into a 64-bit hold register and go to STALL.
  - STALL: `rsp_valid=1`, rdata from the hold register, until `rsp_ready`.
  - On rsp fire with no new cmd fire -> IDLE; with a new cmd fire -> RD.
- Holdup:
  - Set the cycle after an in-region IFU read.
  - Cleared by any `ext_sram_req`, by an out-of-region fire, or by reset.
  - A new IFU read keeps it set; the SRAM output then belongs to the new address.
- Reset: state IDLE, `cmd_ready=1`, `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`, `holdup=0`, `itcm_ram_cs=0`.
- Reset during RD/STALL: the pending response is dropped; the IFU side is reset together with this block.

## Timing
- Latency: cmd fire in cycle T -> `rsp_valid` in cycle T+1, for both hits and errors.
- Throughput is 1 command/cycle while `rsp_ready` stays high.
- Without the buffer (base build): `cmd_ready = ~ext_sram_req & (state==IDLE | rsp_fire)`. This is a combinational `rsp_ready` -> `cmd_ready` path.
- `ext_sram_req` in the same cycle as a pending cmd_valid: the cmd stalls, no `cs`, and the response state is unaffected.
- `itcm_ram_dout` is only sampled in the RD cycle; the SRAM is not re-read in STALL.

## Configuration
- `E203_ITCM_RSP_BUF_EN` defined:
  - 2-entry response FIFO (rdata+err) replaces the hold register.
  - `cmd_ready = ~ext_sram_req & (fifo_count + inflight < 2)`, with no combinational dependence on `rsp_ready`.
  - Up to 2 commands can be accepted while `rsp_ready` is low.
  - Latency is still T+1 when the FIFO is empty: RD data bypasses the FIFO.
- Undefined: single hold register as above.

## Structure
- Shared package `e203_itcm_pkg`: the response state enum (IDLE/RD/STALL), a struct {rdata[63:0], err}, and `ITCM_DW=64`.
- One sub-module, `e203_itcm_rsp_fifo`: 2-deep, present only under `E203_ITCM_RSP_BUF_EN`.

## Test plan
- Reset held 2 cycles, then released -> `cmd_ready=1`, `rsp_valid=0`, `holdup=0`, `cs=0`.
- Cmd addr 0x8000_0010, `rsp_ready=1`, SRAM returns 0x1122_3344_5566_7788 -> `cs=1` with ram_addr 2 at T; `rsp_valid=1` with that rdata and err=0 at T+1; `holdup=1` from T+1.
- Cmd addr 0x9000_0000 -> no `cs`; at T+1 `rsp_err=1`, `rdata=0`; holdup cleared.
- Read, then `rsp_ready=0` for 3 cycles while dout changes to 0xDEAD -> rdata stays at the original value until `rsp_ready`, then goes IDLE. Base build: `cmd_ready=0` throughout the stall.
- `ext_sram_req=1` with `cmd_valid=1` and holdup set -> `cmd_ready=0`, `cs=0`, holdup=0 next cycle; the cmd fires the cycle after `ext_sram_req` drops.
- With `E203_ITCM_RSP_BUF_EN`: `rsp_ready=0` and 3 back-to-back cmds -> 2 accepted, third stalled. Releasing `rsp_ready` gives responses in order, then the third is accepted.

Source files
------------

// File: rtl/e203_ifu_itcm_rdport_pkg.sv
`default_nettype none
// ============================================================================
//  Module : e203_itcm_pkg
//  Brief  : Shared types for the IFU ITCM read port: response FSM states,
//           response payload struct and data width.
//  Rev    : 1.0  initial release
// ============================================================================
package e203_itcm_pkg;

  localparam int ITCM_DW = 64;

  // Response-side state: nothing pending, SRAM data live, or data held.
  typedef enum logic [1:0] {
    RSP_IDLE  = 2'd0,
    RSP_RD    = 2'd1,
    RSP_STALL = 2'd2
  } rsp_state_e;

  // One response beat as seen by the IFU.
  typedef struct packed {
    logic [ITCM_DW-1:0] rdata;
    logic               err;
  } itcm_rsp_t;

endpackage
`default_nettype wire

// File: rtl/e203_ifu_itcm_rdport_if.sv
`default_nettype none
// ============================================================================
//  Module : e203_ifu_itcm_rdport_if
//  Brief  : IFU-to-ITCM read-only ICB channel (command + response).
//           master = IFU fetch bridge, slave = ITCM read port.
//  Rev    : 1.0  initial release
// ============================================================================
interface e203_ifu_itcm_rdport_if;
  import e203_itcm_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [31:0]        cmd_addr;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_err;
  logic [ITCM_DW-1:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_addr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_addr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

endinterface
`default_nettype wire

// File: rtl/e203_ifu_itcm_rdport_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module : e203_itcm_rsp_fifo
//  Brief  : 2-entry response FIFO (rdata + err) used by the ITCM read port
//           when the response buffer build option is enabled.
//           The caller never pushes when full.
//  Rev    : 1.0  initial release
// ============================================================================
module e203_itcm_rsp_fifo
  import e203_itcm_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  itcm_rsp_t push_data_i,
  input  logic      pop_i,
  output itcm_rsp_t pop_data_o,
  output logic      empty_o,
  output logic [1:0] count_o
);

  itcm_rsp_t  mem_q [2];
  logic       wptr_q;
  logic       rptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;

  // Occupancy follows push/pop; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + 2'd1;
    end else if (!push_i && pop_i) begin
      count_d = count_q - 2'd1;
    end
  end

  // Storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= ~wptr_q;
      end
      if (pop_i) begin
        rptr_q <= ~rptr_q;
      end
      count_q <= count_d;
    end
  end

  assign pop_data_o = mem_q[rptr_q];
  assign empty_o    = (count_q == 2'd0);
  assign count_o    = count_q;

endmodule
`default_nettype wire

// File: rtl/e203_ifu_itcm_rdport.sv
`default_nettype none
// ============================================================================
//  Module : e203_ifu_itcm_rdport
//  Brief  : Read-only ICB slave turning IFU fetch commands into 64-bit ITCM
//           SRAM reads with a T+1 response, plus the holdup indication that
//           lets the fetch bridge reuse the SRAM output.
//           Build option: E203_ITCM_RSP_BUF_EN selects a 2-entry response
//           FIFO instead of the single hold register (default: hold reg).
//  Rev    : 1.0  initial release
// ============================================================================
module e203_ifu_itcm_rdport
  import e203_itcm_pkg::*;
#(
  parameter int          AW        = 16,
  parameter logic [31:0] ITCM_BASE = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  e203_ifu_itcm_rdport_if.slave ifu2itcm_icb,
  output logic                 ifu2itcm_holdup_o,
  input  logic                 ext_sram_req_i,
  output logic                 itcm_ram_cs_o,
  output logic [AW-4:0]        itcm_ram_addr_o,
  input  logic [ITCM_DW-1:0]   itcm_ram_dout_i
);

  logic in_region;
  logic cmd_ready;
  logic cmd_fire;
  logic holdup_q;
  logic holdup_d;
  logic unused_addr_lsb;

  // Doubleword fetches: the byte offset inside the doubleword is irrelevant.
  assign unused_addr_lsb = ^ifu2itcm_icb.cmd_addr[2:0];

  assign in_region = (ifu2itcm_icb.cmd_addr[31:AW] == ITCM_BASE[31:AW]);
  assign cmd_fire  = ifu2itcm_icb.cmd_valid & cmd_ready;
  assign ifu2itcm_icb.cmd_ready = cmd_ready;

  // SRAM is selected in the fire cycle itself; out-of-region never touches it.
  assign itcm_ram_cs_o   = cmd_fire & in_region;
  assign itcm_ram_addr_o = ifu2itcm_icb.cmd_addr[AW-1:3];

  // SRAM output belongs to the IFU until another master uses the SRAM or an
  // out-of-region fetch makes the previous line irrelevant.
  always_comb begin
    holdup_d = holdup_q;
    if (ext_sram_req_i) begin
      holdup_d = 1'b0;
    end else if (cmd_fire) begin
      holdup_d = in_region;
    end
  end

  // Holdup flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      holdup_q <= 1'b0;
    end else begin
      holdup_q <= holdup_d;
    end
  end

  assign ifu2itcm_holdup_o = holdup_q;

`ifdef E203_ITCM_RSP_BUF_EN

  rsp_state_e state_q;
  logic       err_q;
  logic       inflight;
  logic [1:0] fifo_count;
  logic [1:0] occupancy;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  itcm_rsp_t  rd_rsp;
  itcm_rsp_t  fifo_head;
  itcm_rsp_t  rsp_head;

  // A response is in flight in the cycle after a fire; RD lasts one cycle.
  assign inflight  = (state_q == RSP_RD);
  assign occupancy = fifo_count + {1'b0, inflight};

  // Only FIFO occupancy gates acceptance, so no rsp_ready -> cmd_ready path.
  assign cmd_ready = ~ext_sram_req_i & (occupancy < 2'd2);

  assign rd_rsp.rdata = err_q ? '0 : itcm_ram_dout_i;
  assign rd_rsp.err   = err_q;

  // Empty FIFO: RD data goes straight out, keeping T+1 latency.
  assign rsp_head  = fifo_empty ? rd_rsp : fifo_head;
  assign fifo_pop  = ~fifo_empty & ifu2itcm_icb.rsp_ready;
  assign fifo_push = inflight & ~(fifo_empty & ifu2itcm_icb.rsp_ready);

  assign ifu2itcm_icb.rsp_valid = inflight | ~fifo_empty;
  assign ifu2itcm_icb.rsp_err   = ifu2itcm_icb.rsp_valid & rsp_head.err;
  assign ifu2itcm_icb.rsp_rdata = ifu2itcm_icb.rsp_valid ? rsp_head.rdata : '0;

  // In-flight tracking: RD follows every fire; the error tag rides along.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RSP_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= cmd_fire ? RSP_RD : RSP_IDLE;
      if (cmd_fire) begin
        err_q <= ~in_region;
      end
    end
  end

  e203_itcm_rsp_fifo u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (rd_rsp),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

`else

  rsp_state_e         state_q;
  logic               err_q;
  itcm_rsp_t          hold_q;
  logic               rsp_fire;
  logic [ITCM_DW-1:0] rd_data;

  assign rsp_fire  = ifu2itcm_icb.rsp_valid & ifu2itcm_icb.rsp_ready;
  // Accept only when the response slot is free or frees up this cycle.
  assign cmd_ready = ~ext_sram_req_i & ((state_q == RSP_IDLE) | rsp_fire);
  assign rd_data   = err_q ? '0 : itcm_ram_dout_i;

  assign ifu2itcm_icb.rsp_valid = (state_q != RSP_IDLE);

  // Response mux: live SRAM data in RD, captured copy in STALL.
  always_comb begin
    ifu2itcm_icb.rsp_err   = 1'b0;
    ifu2itcm_icb.rsp_rdata = '0;
    case (state_q)
      RSP_RD: begin
        ifu2itcm_icb.rsp_err   = err_q;
        ifu2itcm_icb.rsp_rdata = rd_data;
      end
      RSP_STALL: begin
        ifu2itcm_icb.rsp_err   = hold_q.err;
        ifu2itcm_icb.rsp_rdata = hold_q.rdata;
      end
      default: ;
    endcase
  end

  // Response FSM; SRAM output is captured once on entry to STALL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RSP_IDLE;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      if (cmd_fire) begin
        err_q <= ~in_region;
      end
      case (state_q)
        RSP_IDLE: begin
          if (cmd_fire) begin
            state_q <= RSP_RD;
          end
        end
        RSP_RD: begin
          if (ifu2itcm_icb.rsp_ready) begin
            state_q <= cmd_fire ? RSP_RD : RSP_IDLE;
          end else begin
            state_q <= RSP_STALL;
            hold_q  <= '{rdata: rd_data, err: err_q};
          end
        end
        RSP_STALL: begin
          if (ifu2itcm_icb.rsp_ready) begin
            state_q <= cmd_fire ? RSP_RD : RSP_IDLE;
          end
        end
        default: state_q <= RSP_IDLE;
      endcase
    end
  end

`endif

endmodule
`default_nettype wire

// File: tb/tb_e203_ifu_itcm_rdport.sv
`default_nettype none
// ============================================================================
//  Module : tb_e203_ifu_itcm_rdport
//  Brief  : Directed self-checking bench for the IFU ITCM read port.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_e203_ifu_itcm_rdport;
  import e203_itcm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_sram_req;
  logic        holdup;
  logic        ram_cs;
  logic [12:0] ram_addr;
  logic [63:0] ram_dout;

  int n_cmp = 0;
  int n_bad = 0;

  e203_ifu_itcm_rdport_if bus ();

  e203_ifu_itcm_rdport #(
    .AW        (16),
    .ITCM_BASE (32'h8000_0000)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ifu2itcm_icb      (bus),
    .ifu2itcm_holdup_o (holdup),
    .ext_sram_req_i    (ext_sram_req),
    .itcm_ram_cs_o     (ram_cs),
    .itcm_ram_addr_o   (ram_addr),
    .itcm_ram_dout_i   (ram_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Step just past the active edge; inputs change here, checks follow #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete read with rsp_ready high: command cycle, response cycle, idle.
  task automatic rd_txn(input string tag, input logic [31:0] a, input logic [63:0] d,
                        input logic hit, input logic [12:0] idx);
    tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    #1;
    chk({tag, ".cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    chk({tag, ".cs"}, 64'(ram_cs), 64'(hit));
    if (hit) chk({tag, ".ram_addr"}, 64'(ram_addr), 64'(idx));
    tick();
    bus.cmd_valid = 1'b0;
    ram_dout      = d;
    #1;
    chk({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({tag, ".rsp_err"}, 64'(bus.rsp_err), 64'(!hit));
    chk({tag, ".rdata"}, bus.rsp_rdata, hit ? d : 64'd0);
    chk({tag, ".holdup"}, 64'(holdup), 64'(hit));
    tick();
    #1;
    chk({tag, ".idle"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  logic [31:0] v_addr [5];
  logic [63:0] v_data [5];
  logic        v_hit  [5];
  logic [12:0] v_idx  [5];

  initial begin
    v_addr[0] = 32'h8000_0010; v_data[0] = 64'h1122_3344_5566_7788; v_hit[0] = 1'b1; v_idx[0] = 13'd2;
    v_addr[1] = 32'h9000_0000; v_data[1] = 64'hCAFE_F00D_0000_1111; v_hit[1] = 1'b0; v_idx[1] = 13'd0;
    v_addr[2] = 32'h8000_FFFC; v_data[2] = 64'h0F0E_0D0C_0B0A_0908; v_hit[2] = 1'b1; v_idx[2] = 13'h1FFF;
    v_addr[3] = 32'h8001_0000; v_data[3] = 64'h5555_AAAA_5555_AAAA; v_hit[3] = 1'b0; v_idx[3] = 13'd0;
    v_addr[4] = 32'h8000_0000; v_data[4] = 64'h7766_5544_3322_1100; v_hit[4] = 1'b1; v_idx[4] = 13'd0;

    rst           = 1'b1;
    ext_sram_req  = 1'b0;
    ram_dout      = 64'd0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 32'd0;
    bus.rsp_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("reset.cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("reset.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset.rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("reset.rdata", bus.rsp_rdata, 64'd0);
    chk("reset.holdup", 64'(holdup), 64'd0);
    chk("reset.cs", 64'(ram_cs), 64'd0);

    // Hits, errors and region boundaries.
    for (int i = 0; i < 5; i++) begin
      rd_txn($sformatf("txn%0d", i), v_addr[i], v_data[i], v_hit[i], v_idx[i]);
    end

    // Response stall: data must stay at the captured value while dout moves.
    tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h8000_0018;
    #1;
    chk("stall.cs", 64'(ram_cs), 64'd1);
    chk("stall.ram_addr", 64'(ram_addr), 64'd3);
    tick();
    bus.cmd_valid = 1'b0;
    ram_dout      = 64'hAABB_CCDD_0011_2233;
    bus.rsp_ready = 1'b0;
    #1;
    chk("stall.rd_valid", 64'(bus.rsp_valid), 64'd1);
    chk("stall.rd_rdata", bus.rsp_rdata, 64'hAABB_CCDD_0011_2233);
`ifndef E203_ITCM_RSP_BUF_EN
    chk("stall.rd_cmd_ready", 64'(bus.cmd_ready), 64'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      ram_dout = 64'h0000_0000_0000_DEAD;
      #1;
      chk($sformatf("stall%0d.valid", i), 64'(bus.rsp_valid), 64'd1);
      chk($sformatf("stall%0d.rdata", i), bus.rsp_rdata, 64'hAABB_CCDD_0011_2233);
      chk($sformatf("stall%0d.err", i), 64'(bus.rsp_err), 64'd0);
`ifndef E203_ITCM_RSP_BUF_EN
      chk($sformatf("stall%0d.cmd_ready", i), 64'(bus.cmd_ready), 64'd0);
`endif
    end
    tick();
    bus.rsp_ready = 1'b1;
    #1;
    chk("stall.release_valid", 64'(bus.rsp_valid), 64'd1);
    chk("stall.release_rdata", bus.rsp_rdata, 64'hAABB_CCDD_0011_2233);
    tick();
    #1;
    chk("stall.idle", 64'(bus.rsp_valid), 64'd0);
    chk("stall.holdup", 64'(holdup), 64'd1);

    // External SRAM request blocks the command and clears holdup.
    tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h8000_0020;
    ext_sram_req  = 1'b1;
    #1;
    chk("ext.cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("ext.cs", 64'(ram_cs), 64'd0);
    chk("ext.holdup_before", 64'(holdup), 64'd1);
    tick();
    ext_sram_req = 1'b0;
    #1;
    chk("ext.holdup_cleared", 64'(holdup), 64'd0);
    chk("ext.no_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("ext.retry_ready", 64'(bus.cmd_ready), 64'd1);
    chk("ext.retry_cs", 64'(ram_cs), 64'd1);
    chk("ext.retry_addr", 64'(ram_addr), 64'd4);
    tick();
    bus.cmd_valid = 1'b0;
    ram_dout      = 64'h0102_0304_0506_0708;
    #1;
    chk("ext.rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("ext.rdata", bus.rsp_rdata, 64'h0102_0304_0506_0708);
    chk("ext.holdup_set", 64'(holdup), 64'd1);
    tick();
    #1;
    chk("ext.idle", 64'(bus.rsp_valid), 64'd0);

    // Back-to-back commands with rsp_ready high.
    tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h8000_0028;
    #1;
    chk("b2b.cs0", 64'(ram_cs), 64'd1);
    chk("b2b.addr0", 64'(ram_addr), 64'd5);
    tick();
    bus.cmd_addr = 32'h8000_0030;
    ram_dout     = 64'h5555_0000_0000_0005;
    #1;
    chk("b2b.valid0", 64'(bus.rsp_valid), 64'd1);
    chk("b2b.rdata0", bus.rsp_rdata, 64'h5555_0000_0000_0005);
    chk("b2b.ready1", 64'(bus.cmd_ready), 64'd1);
    chk("b2b.cs1", 64'(ram_cs), 64'd1);
    chk("b2b.addr1", 64'(ram_addr), 64'd6);
    tick();
    bus.cmd_valid = 1'b0;
    ram_dout      = 64'h6666_0000_0000_0006;
    #1;
    chk("b2b.valid1", 64'(bus.rsp_valid), 64'd1);
    chk("b2b.rdata1", bus.rsp_rdata, 64'h6666_0000_0000_0006);
    tick();
    #1;
    chk("b2b.idle", 64'(bus.rsp_valid), 64'd0);

`ifdef E203_ITCM_RSP_BUF_EN
    // Buffered build: two commands accepted under backpressure, third waits.
    tick();
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h8000_0040;
    #1;
    chk("buf.ready0", 64'(bus.cmd_ready), 64'd1);
    chk("buf.cs0", 64'(ram_cs), 64'd1);
    tick();
    bus.cmd_addr = 32'h8000_0048;
    ram_dout     = 64'hE000_0000_0000_0008;
    #1;
    chk("buf.ready1", 64'(bus.cmd_ready), 64'd1);
    chk("buf.cs1", 64'(ram_cs), 64'd1);
    chk("buf.rdata_a", bus.rsp_rdata, 64'hE000_0000_0000_0008);
    tick();
    bus.cmd_addr = 32'h8000_0050;
    ram_dout     = 64'hE100_0000_0000_0009;
    #1;
    chk("buf.ready2_blocked", 64'(bus.cmd_ready), 64'd0);
    chk("buf.cs2_blocked", 64'(ram_cs), 64'd0);
    chk("buf.head_a", bus.rsp_rdata, 64'hE000_0000_0000_0008);
    tick();
    ram_dout      = 64'h0000_0000_0000_DEAD;
    bus.rsp_ready = 1'b1;
    #1;
    chk("buf.full_ready", 64'(bus.cmd_ready), 64'd0);
    chk("buf.pop_a", bus.rsp_rdata, 64'hE000_0000_0000_0008);
    tick();
    #1;
    chk("buf.ready2", 64'(bus.cmd_ready), 64'd1);
    chk("buf.cs2", 64'(ram_cs), 64'd1);
    chk("buf.addr2", 64'(ram_addr), 64'd10);
    chk("buf.pop_b", bus.rsp_rdata, 64'hE100_0000_0000_0009);
    tick();
    bus.cmd_valid = 1'b0;
    ram_dout      = 64'hE200_0000_0000_000A;
    #1;
    chk("buf.valid_c", 64'(bus.rsp_valid), 64'd1);
    chk("buf.rdata_c", bus.rsp_rdata, 64'hE200_0000_0000_000A);
    tick();
    #1;
    chk("buf.idle", 64'(bus.rsp_valid), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
